// File: rtl/event_packetizer.sv
// Event packetizer: snapshots per-unit spike/event flags on a sample strobe,
// scans the units one per cycle and queues a timestamped packet per active unit.
module event_packetizer #(
    parameter int NUM_UNITS  = 4,
    parameter int UID_WIDTH  = 2,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_UNITS-1:0]            spike_detection_array,
    input  logic [2*NUM_UNITS-1:0]          event_out_array,
    input  logic                            sample_strobe,
    output logic [TS_WIDTH+UID_WIDTH+2:0]   pkt_data,
    output logic                            pkt_valid,
    input  logic                            pkt_ready,
    output logic                            busy,
    output logic                            overflow,
    output logic [7:0]                      drop_count
);

    localparam int PW = TS_WIDTH + UID_WIDTH + 3;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [UID_WIDTH-1:0] LAST = UID_WIDTH'(NUM_UNITS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                   state_q, state_d;
    logic [UID_WIDTH-1:0]     idx_q, idx_d;
    logic [TS_WIDTH-1:0]      ts_q, ts_d;
    logic [TS_WIDTH-1:0]      snap_ts_q, snap_ts_d;
    logic [NUM_UNITS-1:0]     snap_spk_q, snap_spk_d;
    logic [2*NUM_UNITS-1:0]   snap_evt_q, snap_evt_d;

    logic [PW-1:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_q, wr_d;
    logic [AW-1:0]            rd_q, rd_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     ovf_q, ovf_d;
    logic [7:0]               drop_q, drop_d;

    logic                     cur_spk;
    logic [1:0]               cur_code;
    logic                     push;
    logic                     strobe_drop;
    logic                     full;
    logic                     push_ok;
    logic                     push_drop;
    logic                     pop;
    logic [8:0]               drop_sum;
    logic [PW-1:0]            push_data;

    assign cur_spk   = snap_spk_q[idx_q];
    assign cur_code  = snap_evt_q[{idx_q, 1'b0} +: 2];
    assign push_data = {snap_ts_q, idx_q, cur_spk, cur_code};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ts_d        = ts_q;
        snap_ts_d   = snap_ts_q;
        snap_spk_d  = snap_spk_q;
        snap_evt_d  = snap_evt_q;
        push        = 1'b0;
        strobe_drop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sample_strobe) begin
                    snap_spk_d = spike_detection_array;
                    snap_evt_d = event_out_array;
                    snap_ts_d  = ts_q;
                    ts_d       = ts_q + 1'b1;
                    idx_d      = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                strobe_drop = sample_strobe;
                push        = cur_spk | (|cur_code);
                if (idx_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Full is judged on registered occupancy, so a same-edge pop never frees room
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign push_ok   = push & ~full;
    assign push_drop = push & full;
    assign pop       = (count_q != '0) & pkt_ready;

    always_comb begin
        wr_d     = wr_q;
        rd_d     = rd_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q | strobe_drop | push_drop;
        drop_sum = {1'b0, drop_q} + 9'(strobe_drop) + 9'(push_drop);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop)     rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ts_q       <= '0;
            snap_ts_q  <= '0;
            snap_spk_q <= '0;
            snap_evt_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ts_q       <= ts_d;
            snap_ts_q  <= snap_ts_d;
            snap_spk_q <= snap_spk_d;
            snap_evt_q <= snap_evt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_data;
    end

    assign pkt_valid  = (count_q != '0);
    assign pkt_data   = pkt_valid ? mem_q[rd_q] : '0;
    assign busy       = (state_q == SCAN);
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_event_packetizer.sv
// Scoreboard bench for event_packetizer; a narrow timestamp keeps the
// wrap-around scenario short.
module tb_event_packetizer;

    localparam int NU    = 4;
    localparam int UW    = 2;
    localparam int TSW   = 8;
    localparam int DEPTH = 16;
    localparam int PW    = TSW + UW + 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NU-1:0]   spk = '0;
    logic [2*NU-1:0] evt = '0;
    logic            strobe = 1'b0;
    logic [PW-1:0]   pkt_data;
    logic            pkt_valid;
    logic            pkt_ready = 1'b0;
    logic            busy;
    logic            overflow;
    logic [7:0]      drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0]  exp_q[$];
    logic [PW-1:0]  got_q[$];
    logic [TSW-1:0] m_ts;
    int             m_occ;
    int             m_drops;

    event_packetizer #(
        .NUM_UNITS(NU), .UID_WIDTH(UW), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spike_detection_array(spk),
        .event_out_array(evt),
        .sample_strobe(strobe),
        .pkt_data(pkt_data),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .busy(busy),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Model of one accepted strobe: packets for active units, FIFO capacity
    task automatic model_strobe(input logic [NU-1:0] s, input logic [2*NU-1:0] e);
        for (int u = 0; u < NU; u++) begin
            if (s[u] || e[2*u +: 2] != 2'b00) begin
                if (m_occ < DEPTH) begin
                    exp_q.push_back({m_ts, UW'(u), s[u], e[2*u +: 2]});
                    m_occ++;
                end else begin
                    m_drops++;
                end
            end
        end
        m_ts = m_ts + 1'b1;
    endtask

    // Ends half a cycle after the capturing edge E0
    task automatic do_strobe(input logic [NU-1:0] s, input logic [2*NU-1:0] e);
        @(negedge clk);
        spk = s; evt = e; strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0; spk = '0; evt = '0;
        model_strobe(s, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete(); got_q.delete();
        m_ts = '0; m_occ = 0; m_drops = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic collect(input int cycles);
        pkt_ready = 1'b1;
        repeat (cycles) begin
            if (pkt_valid) got_q.push_back(pkt_data);
            @(negedge clk);
        end
        pkt_ready = 1'b0;
        m_occ = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", pkt_valid); end
        n_checks++;
        if (pkt_data !== '0) begin n_fail++; $display("FAIL rst_data got %h want 0", pkt_data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow); end
        n_checks++;
        if (drop_count !== 8'd0) begin n_fail++; $display("FAIL rst_drop got %0d want 0", drop_count); end
        do_reset();
    endtask

    task automatic test_single();
        logic [PW-1:0] e;
        do_reset();
        pkt_ready = 1'b1;
        do_strobe(4'b0100, 8'h20);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", pkt_valid); end
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", pkt_valid); end
        n_checks++;
        if (pkt_data !== e) begin n_fail++; $display("FAIL single_data got %h want %h", pkt_data, e); end
        @(negedge clk);
        n_checks++;
        if (pkt_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_after got v=%b b=%b want 0 0", pkt_valid, busy);
        end
        pkt_ready = 1'b0;
    endtask

    task automatic test_all_units();
        logic [PW-1:0] held;
        do_reset();
        do_strobe(4'b1111, 8'h00);
        repeat (5) @(negedge clk);
        n_checks++;
        if (dut.count_q !== 5'd4) begin n_fail++; $display("FAIL all_occ got %0d want 4", dut.count_q); end
        held = pkt_data;
        @(negedge clk);
        n_checks++;
        if (pkt_data !== held) begin n_fail++; $display("FAIL all_stable got %h want %h", pkt_data, held); end
        collect(8);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL all_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [PW-1:0] g, x;
            g = got_q.pop_front(); x = exp_q.pop_front();
            n_checks++;
            if (g !== x) begin n_fail++; $display("FAIL all_pkt got %h want %h", g, x); end
        end
    endtask

    task automatic test_strobe_drop();
        do_reset();
        do_strobe(4'b0001, 8'h00);
        @(negedge clk);
        strobe = 1'b1; spk = 4'b1111;
        @(negedge clk);
        strobe = 1'b0; spk = '0;
        m_drops++;
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL sdrop_ovf got %b want 1", overflow); end
        n_checks++;
        if (drop_count !== 8'(m_drops)) begin
            n_fail++; $display("FAIL sdrop_cnt got %0d want %0d", drop_count, m_drops);
        end
        repeat (4) @(negedge clk);
        do_strobe(4'b0000, 8'h0C);
        repeat (5) @(negedge clk);
        collect(6);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL sdrop_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [PW-1:0] g, x;
            g = got_q.pop_front(); x = exp_q.pop_front();
            n_checks++;
            if (g !== x) begin n_fail++; $display("FAIL sdrop_pkt got %h want %h", g, x); end
        end
    endtask

    task automatic test_fifo_overflow();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            do_strobe(4'b1111, 8'hE4);
            repeat (7) @(negedge clk);
        end
        n_checks++;
        if (dut.count_q !== 5'd16) begin n_fail++; $display("FAIL ovf_occ got %0d want 16", dut.count_q); end
        n_checks++;
        if (drop_count !== 8'(m_drops)) begin
            n_fail++; $display("FAIL ovf_cnt got %0d want %0d", drop_count, m_drops);
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
        collect(20);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ovf_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [PW-1:0] g, x;
            g = got_q.pop_front(); x = exp_q.pop_front();
            n_checks++;
            if (g !== x) begin n_fail++; $display("FAIL ovf_pkt got %h want %h", g, x); end
        end
    endtask

    // Continues from the overflow scenario so drop_count is nonzero going in
    task automatic test_reset_mid_scan();
        do_strobe(4'b1111, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", pkt_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
        n_checks++;
        if (drop_count !== 8'd0) begin n_fail++; $display("FAIL mid_drop got %0d want 0", drop_count); end
        exp_q.delete(); m_ts = '0; m_occ = 0; m_drops = 0;
        @(negedge clk);
        rst = 1'b0;
        do_strobe(4'b0010, 8'h00);
        repeat (5) @(negedge clk);
        collect(4);
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL mid_count got %0d want 1", got_q.size());
        end else begin
            logic [PW-1:0] g, x;
            g = got_q.pop_front(); x = exp_q.pop_front();
            n_checks++;
            if (g !== x) begin n_fail++; $display("FAIL mid_pkt got %h want %h", g, x); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_ts_wrap();
        bit seen = 0;
        do_reset();
        for (int k = 0; k < (1 << TSW) + 1; k++) begin
            do_strobe('0, '0);
            repeat (4) begin
                @(negedge clk);
                if (pkt_valid) seen = 1;
            end
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL wrap_nopkt got valid=1 want 0"); end
        do_strobe(4'b0001, 8'h00);
        repeat (5) @(negedge clk);
        collect(4);
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL wrap_count got %0d want 1", got_q.size());
        end else begin
            logic [PW-1:0] g, x;
            g = got_q.pop_front(); x = exp_q.pop_front();
            n_checks++;
            if (g !== x || g[PW-1 -: TSW] !== TSW'(1)) begin
                n_fail++; $display("FAIL wrap_pkt got %h want %h", g, x);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        m_ts = '0; m_occ = 0; m_drops = 0;
        test_reset();
        test_single();
        test_all_units();
        test_strobe_drop();
        test_fifo_overflow();
        test_reset_mid_scan();
        test_ts_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/event_packetizer.md
EVENT_PACKETIZER -- requirements
Module: event_packetizer

Interface
REQ-001 The block SHALL provide parameter NUM_UNITS, default 4, the number of detector units feeding the block.
REQ-002 The block SHALL provide parameter UID_WIDTH, default 2, the unit-index field width, with NUM_UNITS <= 2**UID_WIDTH.
REQ-003 The block SHALL provide parameter TS_WIDTH, default 16, the timestamp width in sample periods.
REQ-004 The block SHALL provide parameter FIFO_DEPTH, default 16, the packet FIFO depth, a power of two >= 2.
REQ-005 The block SHALL provide port clk, input, 1 bit: the single clock, rising edge active.
REQ-006 The block SHALL provide port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL provide port spike_detection_array, input, NUM_UNITS bits: per-unit spike flags from processing_system.
REQ-008 The block SHALL provide port event_out_array, input, 2*NUM_UNITS bits: per-unit 2-bit event codes, with unit u at bits [2u+1:2u].
REQ-009 The block SHALL provide port sample_strobe, input, 1 bit: a one-cycle pulse marking both input arrays valid for one sample period.
REQ-010 The block SHALL provide port pkt_data, output, TS_WIDTH+UID_WIDTH+3 bits: the FIFO head packet {timestamp, unit_id, spike, event_code[1:0]}, MSB first.
REQ-011 The block SHALL provide port pkt_valid, output, 1 bit: FIFO non-empty.
REQ-012 The block SHALL provide port pkt_ready, input, 1 bit: consumer accept.
REQ-013 The block SHALL provide port busy, output, 1 bit: scanner in state SCAN.
REQ-014 The block SHALL provide port overflow, output, 1 bit: sticky loss flag.
REQ-015 The block SHALL provide port drop_count, output, 8 bits: saturating loss counter.

Function
REQ-016 The block SHALL implement a two-state FSM, IDLE and SCAN.
REQ-017 In IDLE with sample_strobe=1 at edge E0, the block SHALL capture both arrays and the current timestamp into snapshot registers, increment the timestamp modulo 2**TS_WIDTH, clear the scan index to 0 and enter SCAN.
REQ-018 In SCAN, at edges E1..E_NUM_UNITS the block SHALL examine exactly one unit per edge in ascending index order, whether or not the unit is active.
REQ-019 A unit SHALL be active when its spike bit is 1 or its event code is nonzero; an active unit SHALL produce one packet carrying the snapshot timestamp, its index, its spike bit and its code, pushed at that edge.
REQ-020 After the edge examining unit NUM_UNITS-1, the FSM SHALL return to IDLE, so that a strobe is accepted again no earlier than E_(NUM_UNITS+1).
REQ-021 A sample_strobe received while in SCAN SHALL be discarded without a timestamp increment, SHALL set overflow and SHALL increment drop_count.
REQ-022 The FIFO SHALL pop at each edge where pkt_valid=1 and pkt_ready=1; pkt_data SHALL be stable while pkt_valid=1 and pkt_ready=0.
REQ-023 A push SHALL be rejected when the registered occupancy equals FIFO_DEPTH, even if a pop occurs on the same edge; a rejected push SHALL set overflow and SHALL increment drop_count.
REQ-024 A push and a pop on the same edge with the FIFO not full SHALL both complete with occupancy unchanged.
REQ-025 A push into an empty FIFO at edge Ek SHALL make pkt_valid=1 and present the packet on pkt_data immediately after Ek.
REQ-026 drop_count SHALL saturate at 255; a strobe drop and a packet drop on the same edge SHALL add 2, saturating.
REQ-027 overflow SHALL remain set until rst; the timestamp SHALL wrap from 2**TS_WIDTH-1 to 0 silently.

Reset
REQ-028 While rst=1 the block SHALL hold state=IDLE, timestamp=0, scan index=0, FIFO empty, pkt_valid=0, pkt_data=0, busy=0, overflow=0 and drop_count=0.
REQ-029 An assertion of rst during SCAN SHALL abort the scan and SHALL discard all snapshot and FIFO contents.
REQ-030 The first strobe after rst deasserts SHALL carry timestamp 0.

Verification
REQ-031 The bench SHALL cover: strobe with spike=4'b0100, events=8'h20, pkt_ready=1 -> one packet {ts=0, uid=2, spike=1, code=2'b10}, with pkt_valid high after E3.
REQ-032 The bench SHALL cover: all four units active on one strobe, pkt_ready=0 -> four packets, uid 0,1,2,3 in order, all with the same timestamp, occupancy=4.
REQ-033 The bench SHALL cover: a second strobe at E2 -> strobe dropped, overflow=1, drop_count=1, next accepted strobe carries ts=1.
REQ-034 The bench SHALL cover: pkt_ready=0 with 5 strobes of 4 active units each, spaced 9 cycles apart -> 16 packets stored, 4 dropped, drop_count=4, overflow=1.
REQ-035 The bench SHALL cover: 65537 strobes with no active units -> no packets, next active packet carries ts=1.
REQ-036 The bench SHALL cover: rst pulsed at E2 of a 4-unit-active scan -> pkt_valid=0, busy=0, drop_count=0 immediately, and the next packet carries ts=0.
